// File: rtl/amiq_fifo_sync_pkg.sv
// Shared types and default sizing for the amiq_fifo_sync FIFO slice.
package amiq_fifo_sync_pkg;

    localparam int P_DEF          = 4;
    localparam int DATA_WIDTH_DEF = 8;

    // Occupancy count: one bit wider than the pointers so DEPTH is representable.
    typedef logic [P_DEF:0] count_t;

    // Status flags derived from the occupancy count.
    typedef struct packed {
        logic full;
        logic empty;
        logic alm_full;
        logic alm_empty;
    } status_t;

endpackage

// File: rtl/amiq_fifo_sync_if.sv
// Write/read data path bundle between producer, FIFO and consumer.
interface amiq_fifo_sync_if
    import amiq_fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    // Producer/consumer side.
    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid
    );

    // FIFO side.
    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/amiq_fifo_sync_mem.sv
// Simple dual-port register array: synchronous write, registered read.
// The array itself is not reset; only the read register is.
module amiq_fifo_sync_mem #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rd_data_r;

    // Store the incoming word at the write address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Capture the addressed word on a read; hold it otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {DW{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/amiq_fifo_sync.sv
// Single-clock synchronous FIFO with full/empty/almost flags, fill level and
// overflow/underflow pulses. Optional synchronous flush input is enabled by
// defining AMIQ_FIFO_SOFT_FLUSH_EN.
module amiq_fifo_sync
    import amiq_fifo_sync_pkg::*;
#(
    parameter int P          = P_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef AMIQ_FIFO_SOFT_FLUSH_EN
    input  logic                 flush,
`endif
    amiq_fifo_sync_if.slave      bus,
    input  logic [P-1:0]         alm_full_thresh,
    input  logic [P-1:0]         alm_empty_thresh,
    output logic                 full,
    output logic                 empty,
    output logic                 alm_full,
    output logic                 alm_empty,
    output logic [P:0]           fill_level,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int           DEPTH    = 2 ** P;
    localparam logic [P:0]   DEPTH_C  = DEPTH[P:0];
    localparam logic [P:0]   CNT_ONE  = {{P{1'b0}}, 1'b1};
    localparam logic [P-1:0] PTR_ONE  = {{(P-1){1'b0}}, 1'b1};

    logic [P-1:0]          wr_ptr_r;
    logic [P-1:0]          rd_ptr_r;
    logic [P:0]            count_r;
    logic                  rd_valid_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  flush_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    status_t               status_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    // Select the flush source; without the option only rst_n clears state.
    always_comb begin
`ifdef AMIQ_FIFO_SOFT_FLUSH_EN
        flush_s = flush;
`else
        flush_s = 1'b0;
`endif
    end

    // Flags from the count register and the live thresholds (P+1 bit unsigned).
    always_comb begin
        status_s.full      = (count_r == DEPTH_C);
        status_s.empty     = (count_r == {(P+1){1'b0}});
        status_s.alm_full  = ((DEPTH_C - count_r) <= {1'b0, alm_full_thresh});
        status_s.alm_empty = (count_r <= {1'b0, alm_empty_thresh});
    end

    // Accept decisions; flush suppresses both ports for its cycle.
    always_comb begin
        wr_acc_s = bus.wr_en & ~status_s.full  & ~flush_s;
        rd_acc_s = bus.rd_en & ~status_s.empty & ~flush_s;
    end

    // Pointers, occupancy, read-valid and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {P{1'b0}};
            rd_ptr_r    <= {P{1'b0}};
            count_r     <= {(P+1){1'b0}};
            rd_valid_r  <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (flush_s) begin
            wr_ptr_r    <= {P{1'b0}};
            rd_ptr_r    <= {P{1'b0}};
            count_r     <= {(P+1){1'b0}};
            rd_valid_r  <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            rd_valid_r  <= rd_acc_s;
            overflow_r  <= bus.wr_en & status_s.full;
            underflow_r <= bus.rd_en & status_s.empty;
        end
    end

    amiq_fifo_sync_mem #(
        .AW (P),
        .DW (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_r),
        .wr_data (bus.wr_data),
        .rd_en   (rd_acc_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    assign bus.rd_data  = rd_data_s;
    assign bus.rd_valid = rd_valid_r;
    assign full         = status_s.full;
    assign empty        = status_s.empty;
    assign alm_full     = status_s.alm_full;
    assign alm_empty    = status_s.alm_empty;
    assign fill_level   = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: doc/amiq_fifo_sync.md
Name: amiq_fifo_sync

Overview:
- Single-clock synchronous FIFO core; consumes the FIFO control bundle (rst_n, alm_full_thresh, alm_empty_thresh) plus a write/read data path.
- Sits between an upstream producer (write port) and a downstream consumer (read port).
- Provides status flags and error pulses: full, empty, almost-full, almost-empty, fill level, overflow, underflow.

Parameters:
- P, 4: address width; depth DEPTH = 2**P entries.
- DATA_WIDTH, 8: width of each stored word.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write data.
- rd_en  input  1  read request.
- rd_data  output  DATA_WIDTH  read data, registered.
- rd_valid  output  1  rd_data holds the word from the read accepted on the previous cycle.
- alm_full_thresh  input  P  free-space threshold for alm_full.
- alm_empty_thresh  input  P  fill threshold for alm_empty.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- alm_full  output  1  (DEPTH - count) <= alm_full_thresh.
- alm_empty  output  1  count <= alm_empty_thresh.
- fill_level  output  P+1  current count.
- overflow  output  1  one-cycle pulse: write rejected.
- underflow  output  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - wr_ptr, rd_ptr and count = 0.
  - rd_data = 0; rd_valid, overflow, underflow, full, alm_full = 0.
  - empty, alm_empty = 1.
  - Memory contents are not reset.
- Storage: DEPTH x DATA_WIDTH array; P-bit pointers wrap naturally from DEPTH-1 to 0.
- Internal count: P+1 bits.
- Write accept: wr_acc = wr_en & ~full, with full taken from the registered count. Accepted write stores wr_data at wr_ptr, then wr_ptr++.
- Read accept: rd_acc = rd_en & ~empty. Accepted read registers mem[rd_ptr] into rd_data next edge, then rd_ptr++.
  - Read latency: 1 cycle; rd_valid = registered rd_acc.
  - rd_data holds its value when no read is accepted.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- Simultaneous events:
  - Full with wr_en & rd_en: read accepted, write rejected (overflow=1), count becomes DEPTH-1.
  - Empty with wr_en & rd_en: write accepted, read rejected (underflow=1), count becomes 1.
  - No write-to-read bypass.
- Error pulses: overflow = registered (wr_en & full); underflow = registered (rd_en & empty). Each is high for exactly one cycle per rejected request.
- Flag timing:
  - full, empty, fill_level are combinational from the count register.
  - alm_full, alm_empty are combinational from count and the live threshold inputs, so a threshold change takes effect the same cycle.
  - Arithmetic is at P+1 bits, unsigned.
- Threshold boundaries:
  - alm_empty_thresh = 0 means alm_empty == empty.
  - alm_full_thresh = 0 means alm_full == full.
- Reset mid-operation: all state clears immediately; an in-flight rd_valid is dropped.

Optional Feature:
- Macro: AMIQ_FIFO_SOFT_FLUSH_EN.
- With the macro: adds input flush (1 bit).
  - Synchronous flush clears pointers, count, rd_valid, overflow and underflow on the next edge.
  - Flush has priority over wr_en/rd_en in that cycle; rd_data keeps its value.
- Without the macro: no flush port; only rst_n clears state.

Decomposition:
- Package amiq_fifo_sync_pkg holds:
  - default P and DATA_WIDTH constants;
  - a typedef for count (logic [P:0]);
  - a status struct {full, empty, alm_full, alm_empty}.
- One sub-module: amiq_fifo_sync_mem, a simple dual-port register array with sync write and registered read. Pointer/count/flag logic stays in the top module.

Test Plan:
- P=4: write 16 words 0x00..0x0F with no reads -> full=1 after the 16th edge, fill_level=16. A 17th write -> overflow pulses 1 cycle, count stays 16.
- Read 16 words from full -> rd_data 0x00..0x0F in order, each 1 cycle after rd_en. Then empty=1; a further read -> underflow pulse, rd_valid=0.
- alm_full_thresh=3, alm_empty_thresh=2 -> alm_empty=1 for count 0..2 and 0 at count 3; alm_full=0 at count 12 and 1 at count 13.
- At full, wr_en=rd_en=1 for one cycle -> overflow=1, count=15, rd_data=oldest word. At empty, wr_en=rd_en=1 -> underflow=1, count=1.
- Write 20 and read 20 interleaved, crossing the pointer wrap -> in-order data, no flag glitches.
- Assert rst_n=0 mid-burst at count=7 -> outputs reach reset values immediately (without waiting for a clock edge); after release, empty=1 and fill_level=0.
